// File: rtl/i_mem_fill_ctrl_if.sv
// Fill-port bundle between the IFU requesters, i_mem_fill_ctrl and i_mem_wrap.
//   dm_*   : demand-miss request/response
//   pf_*   : next-line prefetch request/response
//   rsp_*  : shared returned line and its line-aligned address
//   mem_*  : one-cycle-valid / sticky-address fill port to memory
//   fill_err : one-cycle timeout pulse
// slave  = the controller's view, master = the requesters' and memory's view.
interface i_mem_fill_ctrl_if #(parameter int CL_WIDTH = 128);
  logic                dm_req_valid;
  logic [31:0]         dm_req_addr;
  logic                dm_req_ready;
  logic                dm_rsp_valid;
  logic                pf_req_valid;
  logic [31:0]         pf_req_addr;
  logic                pf_req_ready;
  logic                pf_rsp_valid;
  logic [CL_WIDTH-1:0] rsp_line;
  logic [31:0]         rsp_addr;
  logic                mem_req_valid;
  logic [31:0]         mem_req_addr;
  logic                mem_rsp_valid;
  logic [CL_WIDTH-1:0] mem_rsp_line;
  logic [31:0]         mem_rsp_addr;
  logic                fill_err;

  modport slave (
    input  dm_req_valid, dm_req_addr, pf_req_valid, pf_req_addr,
           mem_rsp_valid, mem_rsp_line, mem_rsp_addr,
    output dm_req_ready, dm_rsp_valid, pf_req_ready, pf_rsp_valid,
           rsp_line, rsp_addr, mem_req_valid, mem_req_addr, fill_err
  );

  modport master (
    output dm_req_valid, dm_req_addr, pf_req_valid, pf_req_addr,
           mem_rsp_valid, mem_rsp_line, mem_rsp_addr,
    input  dm_req_ready, dm_rsp_valid, pf_req_ready, pf_rsp_valid,
           rsp_line, rsp_addr, mem_req_valid, mem_req_addr, fill_err
  );
endinterface

// File: rtl/i_mem_fill_ctrl.sv
// Instruction-memory fill controller / arbiter.
// Shares one fill port between the demand-miss path and the next-line
// prefetcher. Demand has fixed priority in IDLE; a request for the line
// already in flight is merged (demand onto prefetch: both get the line;
// prefetch onto demand: prefetch is simply dropped).
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : i_mem_fill_ctrl_if.slave (requests, responses, memory fill port)
// Memory protocol: mem_req_valid is a one-cycle strobe, mem_req_addr is
// sticky (only changes on acceptance), WAIT aborts after TIMEOUT_CYCLES
// cycles without a matching mem_rsp_valid.
module i_mem_fill_ctrl #(
  parameter int CL_WIDTH       = 128,
  parameter int TIMEOUT_CYCLES = 32,   // > 9
  parameter int CNT_W          = 6     // 2**CNT_W > TIMEOUT_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  i_mem_fill_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [31:0]      LINE_MASK = 32'hFFFF_FFF0;
  // Last WAIT cycle: the counter reaches TIMEOUT_CYCLES on this edge.
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              state;
  logic [31:0]         addr_q;
  logic                owner_pf;   // 0: demand owns the fill, 1: prefetch
  logic                dm_merge;   // demand merged onto a prefetch fill
  logic [CNT_W-1:0]    cnt;
  logic                mem_req_valid_q;
  logic                dm_rsp_q, pf_rsp_q, fill_err_q;
  logic [CL_WIDTH-1:0] rsp_line_q;
  logic [31:0]         rsp_addr_q;

  function automatic logic line_eq(input logic [31:0] a, input logic [31:0] b);
    return ((a ^ b) & LINE_MASK) == 32'd0;
  endfunction

  logic idle, busy, dm_hit, pf_hit, dm_merge_now, rsp_hit;

  assign idle   = (state == IDLE);
  assign busy   = (state == ISSUE) || (state == WAIT);
  assign dm_hit = line_eq(bus.dm_req_addr, addr_q);
  assign pf_hit = line_eq(bus.pf_req_addr, addr_q);

  // Demand joining a prefetch fill for the same line.
  assign dm_merge_now = busy && owner_pf && bus.dm_req_valid && dm_hit;
  assign rsp_hit      = bus.mem_rsp_valid && line_eq(bus.mem_rsp_addr, addr_q);

  // Readies are combinational; held low in reset so nothing is accepted.
  assign bus.dm_req_ready = !rst && bus.dm_req_valid &&
                            (idle || (busy && owner_pf && dm_hit));
  assign bus.pf_req_ready = !rst && bus.pf_req_valid &&
                            ((idle && !bus.dm_req_valid) ||
                             (busy && !owner_pf && pf_hit));

  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_addr  = addr_q;
  assign bus.dm_rsp_valid  = dm_rsp_q;
  assign bus.pf_rsp_valid  = pf_rsp_q;
  assign bus.rsp_line      = rsp_line_q;
  assign bus.rsp_addr      = rsp_addr_q;
  assign bus.fill_err      = fill_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      addr_q          <= '0;
      owner_pf        <= 1'b0;
      dm_merge        <= 1'b0;
      cnt             <= '0;
      mem_req_valid_q <= 1'b0;
      dm_rsp_q        <= 1'b0;
      pf_rsp_q        <= 1'b0;
      fill_err_q      <= 1'b0;
      rsp_line_q      <= '0;
      rsp_addr_q      <= '0;
    end else begin
      // Pulse outputs default low.
      mem_req_valid_q <= 1'b0;
      dm_rsp_q        <= 1'b0;
      pf_rsp_q        <= 1'b0;
      fill_err_q      <= 1'b0;
      if (dm_merge_now) dm_merge <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.dm_req_valid) begin
            addr_q          <= bus.dm_req_addr & LINE_MASK;
            owner_pf        <= 1'b0;
            mem_req_valid_q <= 1'b1;
            state           <= ISSUE;
          end else if (bus.pf_req_valid) begin
            addr_q          <= bus.pf_req_addr & LINE_MASK;
            owner_pf        <= 1'b1;
            mem_req_valid_q <= 1'b1;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // A response on the final WAIT cycle still wins over the timeout.
          if (rsp_hit) begin
            rsp_line_q <= bus.mem_rsp_line;
            rsp_addr_q <= addr_q;
            // Include a merge arriving in the capture cycle itself.
            dm_rsp_q   <= !owner_pf || dm_merge || dm_merge_now;
            pf_rsp_q   <= owner_pf;
            state      <= RESP;
          end else if (cnt == TO_LAST) begin
            fill_err_q <= 1'b1;
            owner_pf   <= 1'b0;
            dm_merge   <= 1'b0;
            state      <= IDLE;
          end
        end
        RESP: begin
          owner_pf <= 1'b0;
          dm_merge <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i_mem_fill_ctrl.sv
module tb_i_mem_fill_ctrl;
  localparam int CLW = 128;
  localparam int TO  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i_mem_fill_ctrl_if #(.CL_WIDTH(CLW)) bus ();

  i_mem_fill_ctrl #(.CL_WIDTH(CLW), .TIMEOUT_CYCLES(TO), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {int due; logic [31:0] addr; logic [CLW-1:0] line;} mrsp_t;

  mrsp_t          mq[$];          // pending memory responses
  int             cyc = 0;
  int             mem_lat = 8;    // mem_req_valid cycle -> mem_rsp_valid cycle
  bit             mem_on = 1'b1;  // memory answers requests
  logic [31:0]    seed;
  int             mreq_c[$], dm_c[$], pf_c[$], err_c[$];
  logic [31:0]    mreq_a[$];
  logic [CLW-1:0] last_line;
  logic [31:0]    last_addr;
  int             n_cmp = 0, n_bad = 0;

  // Memory content: any deterministic function of the line address.
  function automatic logic [CLW-1:0] line_of(input logic [31:0] a);
    return {a ^ seed, ~a, a * 32'd2654435761 + seed, seed ^ 32'h5a5a_0000 ^ a};
  endfunction

  function automatic logic [31:0] al(input logic [31:0] a);
    return a - (a % 32'd16);
  endfunction

  function automatic int first(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  task automatic clear_logs();
    mreq_c.delete(); mreq_a.delete(); dm_c.delete(); pf_c.delete(); err_c.delete();
  endtask

  // Advance one cycle: log DUT events of the new cycle, then drive memory.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    if (bus.mem_req_valid === 1'b1) begin
      mreq_c.push_back(cyc);
      mreq_a.push_back(bus.mem_req_addr);
      if (mem_on) mq.push_back('{cyc + mem_lat, bus.mem_req_addr, line_of(bus.mem_req_addr)});
    end
    if (bus.dm_rsp_valid === 1'b1) dm_c.push_back(cyc);
    if (bus.pf_rsp_valid === 1'b1) pf_c.push_back(cyc);
    if (bus.fill_err === 1'b1) err_c.push_back(cyc);
    if (bus.dm_rsp_valid === 1'b1 || bus.pf_rsp_valid === 1'b1) begin
      last_line = bus.rsp_line;
      last_addr = bus.rsp_addr;
    end
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_addr  = $urandom;
    bus.mem_rsp_line  = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].due == cyc) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_addr  = mq[i].addr;
        bus.mem_rsp_line  = mq[i].line;
        mq.delete(i);
        break;
      end
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.dm_req_valid = 1'b0; bus.dm_req_addr = '0;
    bus.pf_req_valid = 1'b0; bus.pf_req_addr = '0;
    bus.mem_rsp_valid = 1'b0; bus.mem_rsp_addr = '0; bus.mem_rsp_line = '0;
    mq.delete();
    tick(); tick();
    n_cmp++;
    if ({bus.mem_req_valid, bus.dm_rsp_valid, bus.pf_rsp_valid, bus.fill_err} !== 4'b0) begin
      n_bad++; $display("FAIL reset_pulses: got %b want 0000",
        {bus.mem_req_valid, bus.dm_rsp_valid, bus.pf_rsp_valid, bus.fill_err});
    end
    n_cmp++;
    if (bus.mem_req_addr !== 32'h0 || bus.rsp_addr !== 32'h0) begin
      n_bad++; $display("FAIL reset_addr: got mem %h rsp %h want 0", bus.mem_req_addr, bus.rsp_addr);
    end
    n_cmp++;
    if (bus.rsp_line !== '0) begin
      n_bad++; $display("FAIL reset_line: got %h want 0", bus.rsp_line);
    end
    bus.dm_req_valid = 1'b1; bus.pf_req_valid = 1'b1; #1;
    n_cmp++;
    if (bus.dm_req_ready !== 1'b0 || bus.pf_req_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_ready: got dm %b pf %b want 0 0", bus.dm_req_ready, bus.pf_req_ready);
    end
    bus.dm_req_valid = 1'b0; bus.pf_req_valid = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_demand();
    int T, bad_hold;
    clear_logs(); T = cyc; bad_hold = 0;
    bus.dm_req_valid = 1'b1; bus.dm_req_addr = 32'h0000_1238; #1;
    n_cmp++;
    if (bus.dm_req_ready !== 1'b1) begin
      n_bad++; $display("FAIL dm_ready_idle: got %b want 1", bus.dm_req_ready);
    end
    tick(); bus.dm_req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (bus.mem_req_addr !== 32'h0000_1230) bad_hold++;
      if (k < 10) tick();
    end
    n_cmp++;
    if (bad_hold != 0) begin
      n_bad++; $display("FAIL dm_addr_hold: got %0d bad cycles want 0", bad_hold);
    end
    n_cmp++;
    if (mreq_c.size() != 1 || first(mreq_c) != T + 1) begin
      n_bad++; $display("FAIL dm_mem_req: got n=%0d at %0d want 1 at %0d", mreq_c.size(), first(mreq_c), T + 1);
    end
    n_cmp++;
    if (dm_c.size() != 1 || first(dm_c) != T + 10 || pf_c.size() != 0) begin
      n_bad++; $display("FAIL dm_rsp: got dm n=%0d at %0d pf n=%0d want dm at %0d only",
        dm_c.size(), first(dm_c), pf_c.size(), T + 10);
    end
    n_cmp++;
    if (last_line !== line_of(32'h0000_1230) || last_addr !== 32'h0000_1230) begin
      n_bad++; $display("FAIL dm_line: got %h @%h want %h @00001230", last_line, last_addr, line_of(32'h1230));
    end
    tick();
  endtask

  task automatic test_priority();
    int T, g;
    clear_logs(); T = cyc; g = -1;
    bus.dm_req_valid = 1'b1; bus.dm_req_addr = 32'h100;
    bus.pf_req_valid = 1'b1; bus.pf_req_addr = 32'h200; #1;
    n_cmp++;
    if (bus.dm_req_ready !== 1'b1 || bus.pf_req_ready !== 1'b0) begin
      n_bad++; $display("FAIL prio_ready: got dm %b pf %b want 1 0", bus.dm_req_ready, bus.pf_req_ready);
    end
    tick(); bus.dm_req_valid = 1'b0;
    for (int k = 0; k < 30 && g < 0; k++) begin
      #1;
      if (bus.pf_req_ready === 1'b1) g = cyc;
      tick();
    end
    bus.pf_req_valid = 1'b0;
    run_to(T + 22);
    n_cmp++;
    if (g != T + 11) begin
      n_bad++; $display("FAIL prio_pf_grant: got %0d want %0d", g, T + 11);
    end
    n_cmp++;
    if (mreq_c.size() != 2 || mreq_c[mreq_c.size()-1] != T + 12 || mreq_a[mreq_a.size()-1] !== 32'h200) begin
      n_bad++; $display("FAIL prio_mem_req: got n=%0d want 2 with second at %0d addr 200", mreq_c.size(), T + 12);
    end
    n_cmp++;
    if (first(dm_c) != T + 10 || pf_c.size() != 1 || first(pf_c) != T + 21) begin
      n_bad++; $display("FAIL prio_rsp: got dm %0d pf %0d want %0d %0d", first(dm_c), first(pf_c), T + 10, T + 21);
    end
    n_cmp++;
    if (last_line !== line_of(32'h200) || last_addr !== 32'h200) begin
      n_bad++; $display("FAIL prio_line: got %h @%h want %h @200", last_line, last_addr, line_of(32'h200));
    end
  endtask

  task automatic test_merge_dm();
    int T;
    clear_logs(); T = cyc;
    bus.pf_req_valid = 1'b1; bus.pf_req_addr = 32'h400; #1;
    n_cmp++;
    if (bus.pf_req_ready !== 1'b1) begin
      n_bad++; $display("FAIL merge_pf_ready: got %b want 1", bus.pf_req_ready);
    end
    tick(); bus.pf_req_valid = 1'b0;
    run_to(T + 4);
    bus.dm_req_valid = 1'b1; bus.dm_req_addr = 32'h40C; #1;
    n_cmp++;
    if (bus.dm_req_ready !== 1'b1) begin
      n_bad++; $display("FAIL merge_dm_ready: got %b want 1", bus.dm_req_ready);
    end
    tick(); bus.dm_req_valid = 1'b0;
    run_to(T + 11);
    n_cmp++;
    if (mreq_c.size() != 1 || first(dm_c) != T + 10 || first(pf_c) != T + 10) begin
      n_bad++; $display("FAIL merge_rsp: got mreq n=%0d dm %0d pf %0d want 1 %0d %0d",
        mreq_c.size(), first(dm_c), first(pf_c), T + 10, T + 10);
    end
    n_cmp++;
    if (last_addr !== 32'h400 || last_line !== line_of(32'h400)) begin
      n_bad++; $display("FAIL merge_line: got %h @%h want %h @400", last_line, last_addr, line_of(32'h400));
    end
  endtask

  task automatic test_drop_pf();
    int T;
    clear_logs(); T = cyc;
    bus.dm_req_valid = 1'b1; bus.dm_req_addr = 32'h800;
    tick(); bus.dm_req_valid = 1'b0;
    run_to(T + 3);
    bus.pf_req_valid = 1'b1; bus.pf_req_addr = 32'h900; #1;
    n_cmp++;
    if (bus.pf_req_ready !== 1'b0) begin
      n_bad++; $display("FAIL drop_other_ready: got %b want 0", bus.pf_req_ready);
    end
    tick(); bus.pf_req_valid = 1'b0;
    tick();
    bus.pf_req_valid = 1'b1; bus.pf_req_addr = 32'h804; #1;
    n_cmp++;
    if (bus.pf_req_ready !== 1'b1) begin
      n_bad++; $display("FAIL drop_match_ready: got %b want 1", bus.pf_req_ready);
    end
    tick(); bus.pf_req_valid = 1'b0;
    run_to(T + 11);
    n_cmp++;
    if (mreq_c.size() != 1 || first(dm_c) != T + 10 || pf_c.size() != 0) begin
      n_bad++; $display("FAIL drop_rsp: got mreq n=%0d dm %0d pf n=%0d want 1 %0d 0",
        mreq_c.size(), first(dm_c), pf_c.size(), T + 10);
    end
  endtask

  task automatic test_timeout();
    int T; logic [31:0] a;
    clear_logs(); T = cyc; mem_on = 1'b0; a = $urandom;
    bus.dm_req_valid = 1'b1; bus.dm_req_addr = a;
    tick(); bus.dm_req_valid = 1'b0;
    run_to(T + 40);
    n_cmp++;
    if (err_c.size() != 1 || first(err_c) != T + 2 + TO) begin
      n_bad++; $display("FAIL timeout_err: got n=%0d at %0d want 1 at %0d", err_c.size(), first(err_c), T + 2 + TO);
    end
    n_cmp++;
    if (dm_c.size() != 0 || pf_c.size() != 0) begin
      n_bad++; $display("FAIL timeout_norsp: got dm n=%0d pf n=%0d want 0 0", dm_c.size(), pf_c.size());
    end
    mq.push_back('{cyc + 2, al(a), line_of(al(a))});
    run_to(cyc + 6);
    n_cmp++;
    if (dm_c.size() != 0 || mreq_c.size() != 1 || err_c.size() != 1) begin
      n_bad++; $display("FAIL timeout_late: got dm n=%0d mreq n=%0d err n=%0d want 0 1 1",
        dm_c.size(), mreq_c.size(), err_c.size());
    end
    mem_on = 1'b1;
  endtask

  task automatic test_timeout_edge();
    int T; logic [31:0] b;
    clear_logs(); T = cyc; mem_on = 1'b0; b = $urandom;
    bus.dm_req_valid = 1'b1; bus.dm_req_addr = b;
    tick(); bus.dm_req_valid = 1'b0;
    mq.push_back('{T + 6, al(b) ^ 32'h10, line_of(al(b) ^ 32'h10)});  // wrong line
    mq.push_back('{T + 1 + TO, al(b), line_of(al(b))});               // last WAIT cycle
    run_to(T + 4 + TO);
    n_cmp++;
    if (dm_c.size() != 1 || first(dm_c) != T + 2 + TO || err_c.size() != 0) begin
      n_bad++; $display("FAIL edge_rsp: got dm n=%0d at %0d err n=%0d want 1 at %0d err 0",
        dm_c.size(), first(dm_c), err_c.size(), T + 2 + TO);
    end
    n_cmp++;
    if (last_line !== line_of(al(b)) || last_addr !== al(b)) begin
      n_bad++; $display("FAIL edge_line: got %h @%h want %h @%h", last_line, last_addr, line_of(al(b)), al(b));
    end
    mem_on = 1'b1;
  endtask

  task automatic test_rst_mid();
    int T; logic [31:0] c;
    clear_logs(); T = cyc;
    bus.dm_req_valid = 1'b1; bus.dm_req_addr = 32'h3000 | ($urandom % 16);
    tick(); bus.dm_req_valid = 1'b0;
    run_to(T + 5);
    rst = 1'b1;
    tick(); rst = 1'b0;
    n_cmp++;
    if (bus.mem_req_addr !== 32'h0 || bus.rsp_addr !== 32'h0 || bus.rsp_line !== '0 ||
        {bus.dm_rsp_valid, bus.pf_rsp_valid, bus.fill_err, bus.mem_req_valid} !== 4'b0) begin
      n_bad++; $display("FAIL rst_mid_outputs: got maddr %h raddr %h line %h want all 0",
        bus.mem_req_addr, bus.rsp_addr, bus.rsp_line);
    end
    run_to(T + 14);
    n_cmp++;
    if (dm_c.size() != 0 || pf_c.size() != 0 || err_c.size() != 0) begin
      n_bad++; $display("FAIL rst_mid_norsp: got dm n=%0d pf n=%0d err n=%0d want 0 0 0",
        dm_c.size(), pf_c.size(), err_c.size());
    end
    clear_logs(); T = cyc; c = $urandom;
    bus.dm_req_valid = 1'b1; bus.dm_req_addr = c;
    tick(); bus.dm_req_valid = 1'b0;
    run_to(T + 11);
    n_cmp++;
    if (first(dm_c) != T + 10 || last_line !== line_of(al(c)) || last_addr !== al(c)) begin
      n_bad++; $display("FAIL rst_mid_after: got dm %0d line %h want %0d line %h",
        first(dm_c), last_line, T + 10, line_of(al(c)));
    end
  endtask

  // Random episodes: one fill plus optionally a second requester during it.
  // kind 0 dm only, 1 pf only, 2 dm+pf together, 3 pf then dm, 4 dm then pf.
  task automatic test_random();
    for (int ep = 0; ep < 24; ep++) begin
      int T, kind, k, lat;
      bit match, first_dm, exp_dm, exp_pf, rdy;
      logic [31:0] a1, a2;
      clear_logs();
      lat  = $urandom_range(1, 20);
      kind = $urandom_range(0, 4);
      a1   = $urandom;
      match = 1'($urandom_range(0, 1));
      a2   = match ? (al(a1) | ($urandom % 16)) : (a1 ^ (32'h10 << $urandom_range(0, 27)));
      k    = $urandom_range(1, lat + 1);
      mem_lat = lat;
      first_dm = (kind != 1) && (kind != 3);
      exp_dm = first_dm || (kind == 3 && match);
      exp_pf = !first_dm;
      T = cyc;
      if (first_dm) begin bus.dm_req_valid = 1'b1; bus.dm_req_addr = a1; end
      else          begin bus.pf_req_valid = 1'b1; bus.pf_req_addr = a1; end
      if (kind == 2) begin bus.pf_req_valid = 1'b1; bus.pf_req_addr = a2; end
      #1;
      rdy = first_dm ? bus.dm_req_ready : bus.pf_req_ready;
      n_cmp++;
      if (rdy !== 1'b1 || (kind == 2 && bus.pf_req_ready !== 1'b0)) begin
        n_bad++; $display("FAIL rnd_first_ready ep%0d kind%0d: got %b pf %b want 1", ep, kind, rdy, bus.pf_req_ready);
      end
      tick(); bus.dm_req_valid = 1'b0; bus.pf_req_valid = 1'b0;
      if (kind >= 3) begin
        run_to(T + k);
        if (kind == 3) begin bus.dm_req_valid = 1'b1; bus.dm_req_addr = a2; end
        else           begin bus.pf_req_valid = 1'b1; bus.pf_req_addr = a2; end
        #1;
        rdy = (kind == 3) ? bus.dm_req_ready : bus.pf_req_ready;
        n_cmp++;
        if (rdy !== match) begin
          n_bad++; $display("FAIL rnd_second_ready ep%0d kind%0d k%0d: got %b want %b", ep, kind, k, rdy, match);
        end
        tick(); bus.dm_req_valid = 1'b0; bus.pf_req_valid = 1'b0;
      end
      run_to(T + lat + 3);
      n_cmp++;
      if (mreq_c.size() != 1 || mreq_a[0] !== al(a1)) begin
        n_bad++; $display("FAIL rnd_mem_req ep%0d: got n=%0d addr %h want 1 %h", ep, mreq_c.size(),
          (mreq_a.size() > 0) ? mreq_a[0] : 32'hx, al(a1));
      end
      n_cmp++;
      if (dm_c.size() != int'(exp_dm) || (exp_dm && first(dm_c) != T + lat + 2) ||
          pf_c.size() != int'(exp_pf) || (exp_pf && first(pf_c) != T + lat + 2)) begin
        n_bad++; $display("FAIL rnd_rsp ep%0d kind%0d match%0d: got dm n=%0d@%0d pf n=%0d@%0d want dm %0d pf %0d @%0d",
          ep, kind, match, dm_c.size(), first(dm_c), pf_c.size(), first(pf_c), exp_dm, exp_pf, T + lat + 2);
      end
      n_cmp++;
      if (last_line !== line_of(al(a1)) || last_addr !== al(a1)) begin
        n_bad++; $display("FAIL rnd_line ep%0d: got %h @%h want %h @%h", ep, last_line, last_addr,
          line_of(al(a1)), al(a1));
      end
      run_to(cyc + $urandom_range(0, 2));
    end
    mem_lat = 8;
  endtask

  initial begin
    seed = $urandom;
    test_reset();
    test_demand();
    test_priority();
    test_merge_dm();
    test_drop_pf();
    test_timeout();
    test_timeout_edge();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
